sd_word_streamer: RTL and testbench



---
 rtl/sd_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/sd_word_streamer.sv | 149 ++++++++++++++
 tb/tb_sd_word_streamer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD word streamer and its sd_control handshake.
package sd_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_CAPTURE,
    ST_RELEASE,
    ST_DRAIN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset, synchronous flush and zero-gated head output.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sd_word_streamer.sv
// Sequences per-word sd_control reads for a multi-word request and streams the words out through a FIFO.
module sd_word_streamer
  import sd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_done,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              sd_read,
  output logic [ADDR_W-1:0] addr,
  input  logic              read_start,
  input  logic              read_done,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   remaining_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          waiting;
  logic          timed_out;
  logic          push;
  logic          pop;

  assign waiting   = state_q inside {ST_WAIT_START, ST_WAIT_DONE, ST_RELEASE};
  assign timed_out = waiting && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign push      = (state_q == ST_CAPTURE);
  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != '0);

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          if (!init_done)              state_d = ST_ERROR;
          else if (word_count == '0)   state_d = ST_IDLE;
          else                         state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:      if (!fifo_full) state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (timed_out)       state_d = ST_ERROR;
        else if (read_start) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (timed_out)       state_d = ST_ERROR;
        else if (read_done)  state_d = ST_CAPTURE;
      end
      ST_CAPTURE:    state_d = ST_RELEASE;
      // Holding here until read_done falls keeps a long read_done level from being sampled twice.
      ST_RELEASE: begin
        if (timed_out)       state_d = ST_ERROR;
        else if (!read_done) state_d = (remaining_q != '0) ? ST_ISSUE : ST_DRAIN;
      end
      ST_DRAIN:      if (fifo_empty) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      addr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      sd_read     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_d != state_q || !waiting) ? '0 : timer_q + 1'b1;
      done    <= 1'b0;

      if (timed_out) begin
        sd_read <= 1'b0;
        busy    <= 1'b0;
        error   <= 1'b1;
      end

      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            if (!init_done) begin
              error <= 1'b1;
            end else if (word_count == '0) begin
              error <= 1'b0;
              done  <= 1'b1;
            end else begin
              error       <= 1'b0;
              busy        <= 1'b1;
              addr        <= base_addr;
              remaining_q <= word_count;
            end
          end
        end
        ST_ISSUE:   if (!fifo_full) sd_read <= 1'b1;
        ST_CAPTURE: begin
          sd_read     <= 1'b0;
          addr        <= addr + ADDR_W'(WORD_BYTES);
          remaining_q <= remaining_q - 1'b1;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (timed_out),
    .push    (push),
    .wdata   (data),
    .pop     (pop),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_sd_word_streamer.sv
// Self-checking bench: behavioural sd_control responder, word-stream scoreboard and directed scenarios.
module tb_sd_word_streamer;

  localparam int DEPTH = 8;
  localparam int TMO   = 50;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        init_done  = 1'b1;
  logic        start      = 1'b0;
  logic [31:0] base_addr  = '0;
  logic [15:0] word_count = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic        sd_read;
  logic [31:0] addr;
  logic        read_start = 1'b0;
  logic        read_done  = 1'b0;
  logic [31:0] data       = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready  = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] pop_log[$];
  int          txn_count  = 0;
  int          done_count = 0;
  logic        prev_done  = 1'b0;

  int          mdl_phase   = 0;
  int          mdl_cnt     = 0;
  int          done_delay  = 5;
  int          hold_cycles = 1;
  bit          never_done  = 1'b0;
  logic [31:0] mdl_addr    = '0;

  always #5 clk = ~clk;

  sd_word_streamer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .init_done  (init_done),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .sd_read    (sd_read),
    .addr       (addr),
    .read_start (read_start),
    .read_done  (read_done),
    .data       (data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return 32'hBAD0_BAD0;
  endfunction

  // sd_control responder: read_start right after sd_read, read_done done_delay cycles later,
  // returning data equal to the word address, held for at least hold_cycles.
  always @(negedge clk) begin
    if (!reset_n) begin
      mdl_phase  = 0;
      mdl_cnt    = 0;
      read_start = 1'b0;
      read_done  = 1'b0;
    end else begin
      case (mdl_phase)
        0: if (sd_read) begin
          mdl_addr = addr;
          txn_count++;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL txn_unexpected: got addr 0x%08h expected no transaction", addr);
          end else begin
            check("txn_addr", addr, exp_addr_q.pop_front());
          end
          read_start = 1'b1;
          mdl_cnt    = 0;
          mdl_phase  = 1;
        end
        1: begin
          read_start = 1'b0;
          mdl_cnt++;
          if (!sd_read) begin
            mdl_phase = 0;
          end else if (!never_done && mdl_cnt >= done_delay) begin
            read_done = 1'b1;
            data      = mdl_addr;
            mdl_cnt   = 0;
            mdl_phase = 2;
          end
        end
        default: begin
          mdl_cnt++;
          if (mdl_cnt >= hold_cycles && !sd_read) begin
            read_done = 1'b0;
            mdl_phase = 0;
          end
        end
      endcase
    end
  end

  // Output scoreboard: every accepted word must be the next expected address-ordered word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got 0x%08h expected no word", out_data);
        end else begin
          check("out_data", out_data, exp_data_q.pop_front());
        end
        pop_log.push_back(out_data);
      end
      if (done) begin
        done_count++;
        check("done_single_cycle", 32'(prev_done), 32'd0);
      end
      if (sd_read) check("sd_read_implies_busy", 32'(busy), 32'd1);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n, input bit accept);
    if (accept) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr_q.push_back(b + 32'(4 * i));
        exp_data_q.push_back(b + 32'(4 * i));
      end
    end
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d0;
    int n;

    reset_n = 1'b0;
    cyc(3);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_sd_read",   32'(sd_read),   32'd0);
    check("rst_addr",      addr,           32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Basic three-word read.
    pop_log.delete();
    t0 = txn_count;
    d0 = done_count;
    do_start(32'h0000_0200, 16'd3, 1'b1);
    check("basic_busy", 32'(busy), 32'd1);
    wait_done("basic_done", 200);
    cyc(2);
    check("basic_words", 32'(pop_log.size()), 32'd3);
    check("basic_w0", log_at(0), 32'h0000_0200);
    check("basic_w1", log_at(1), 32'h0000_0204);
    check("basic_w2", log_at(2), 32'h0000_0208);
    check("basic_txns", 32'(txn_count - t0), 32'd3);
    check("basic_done_pulses", 32'(done_count - d0), 32'd1);
    check("basic_busy_fall", 32'(busy), 32'd0);
    check("basic_error", 32'(error), 32'd0);

    // Zero-length request.
    t0 = txn_count;
    do_start(32'h0000_0300, 16'd0, 1'b0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    cyc(1);
    check("zero_done_fall", 32'(done), 32'd0);
    cyc(3);
    check("zero_txns", 32'(txn_count - t0), 32'd0);

    // Start before the card is initialised.
    t0 = txn_count;
    init_done = 1'b0;
    do_start(32'h0000_0400, 16'd2, 1'b0);
    init_done = 1'b1;
    check("guard_error", 32'(error), 32'd1);
    check("guard_busy", 32'(busy), 32'd0);
    cyc(5);
    check("guard_txns", 32'(txn_count - t0), 32'd0);
    check("guard_sd_read", 32'(sd_read), 32'd0);

    // Restart from error, with a second start while busy that must be ignored.
    pop_log.delete();
    t0 = txn_count;
    d0 = done_count;
    do_start(32'h0000_0800, 16'd4, 1'b1);
    check("restart_error_clear", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    cyc(3);
    do_start(32'h0000_9000, 16'd2, 1'b0);
    wait_done("busy_ignore_done", 300);
    cyc(2);
    check("busy_ignore_words", 32'(pop_log.size()), 32'd4);
    check("busy_ignore_last", log_at(3), 32'h0000_080C);
    check("busy_ignore_txns", 32'(txn_count - t0), 32'd4);
    check("busy_ignore_done_pulses", 32'(done_count - d0), 32'd1);

    // Backpressure: FIFO fills at DEPTH words, issue stalls, then drains.
    out_ready = 1'b0;
    pop_log.delete();
    t0 = txn_count;
    do_start(32'h0000_2000, 16'd12, 1'b1);
    cyc(150);
    check("bp_txn_cap", 32'(txn_count - t0), 32'd8);
    check("bp_sd_read_idle", 32'(sd_read), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head", out_data, 32'h0000_2000);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    wait_done("bp_done", 400);
    cyc(2);
    check("bp_txns", 32'(txn_count - t0), 32'd12);
    check("bp_words", 32'(pop_log.size()), 32'd12);
    check("bp_last", log_at(11), 32'h0000_202C);
    check("bp_scoreboard_empty", 32'(exp_data_q.size()), 32'd0);

    // Timeout: responder never returns read_done.
    never_done = 1'b1;
    t0 = txn_count;
    do_start(32'h0000_0500, 16'd2, 1'b1);
    n = 0;
    while (error !== 1'b1 && n < TMO + 40) begin
      cyc(1);
      n++;
    end
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_not_early", 32'(n >= TMO), 32'd1);
    check("tmo_sd_read", 32'(sd_read), 32'd0);
    check("tmo_out_valid", 32'(out_valid), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_txns", 32'(txn_count - t0), 32'd1);
    exp_addr_q.delete();
    exp_data_q.delete();
    never_done = 1'b0;
    cyc(2);
    pop_log.delete();
    do_start(32'h0000_0600, 16'd1, 1'b1);
    check("tmo_recover_error", 32'(error), 32'd0);
    wait_done("tmo_recover_done", 200);
    cyc(2);
    check("tmo_recover_words", 32'(pop_log.size()), 32'd1);
    check("tmo_recover_w0", log_at(0), 32'h0000_0600);

    // Reset while word 2 of 5 waits for read_done.
    t0 = txn_count;
    do_start(32'h0000_1000, 16'd5, 1'b1);
    n = 0;
    while (!(txn_count == t0 + 2 && mdl_phase == 1) && n < 200) begin
      cyc(1);
      n++;
    end
    check("rst_mid_reached", 32'(txn_count - t0), 32'd2);
    reset_n = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    cyc(1);
    check("rst_mid_sd_read", 32'(sd_read), 32'd0);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", addr, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    pop_log.delete();
    do_start(32'h0000_3000, 16'd2, 1'b1);
    wait_done("rst_fresh_done", 200);
    cyc(2);
    check("rst_fresh_words", 32'(pop_log.size()), 32'd2);
    check("rst_fresh_w0", log_at(0), 32'h0000_3000);
    check("rst_fresh_w1", log_at(1), 32'h0000_3004);

    // Address wrap with read_done held high for ten cycles per word.
    hold_cycles = 10;
    pop_log.delete();
    t0 = txn_count;
    do_start(32'hFFFF_FFFC, 16'd2, 1'b1);
    wait_done("wrap_done", 300);
    cyc(2);
    check("wrap_txns", 32'(txn_count - t0), 32'd2);
    check("wrap_words", 32'(pop_log.size()), 32'd2);
    check("wrap_w0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_w1", log_at(1), 32'h0000_0000);
    hold_cycles = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
